// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit: request/ack memory access, store lane formatting, load extension.
// Optional MEM_MISALIGN_TRAP_EN: misaligned H/W accesses skip the bus and pulse misaligned in DONE.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic [31:0] load_data,
  output logic        busywait,
  output logic        bus_err,
  output logic        misaligned
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    state_q, state_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic [1:0]    off_q, off_d;
  logic [2:0]    f3_q, f3_d;
  logic [31:0]   load_q, load_d;
  logic          err_q, err_d;
  logic          mis_q, mis_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          access;
  logic          bad_align;

  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  fmt_load = {{24{b[7]}}, b};
      3'b100:  fmt_load = {24'b0, b};
      3'b001:  fmt_load = {{16{h[15]}}, h};
      3'b101:  fmt_load = {16'b0, h};
      default: fmt_load = w;
    endcase
  endfunction

  assign access = mem_read | mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
  assign bad_align = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3 == 3'b010) && (addr[1:0] != 2'b00));
`else
  assign bad_align = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    off_d   = off_q;
    f3_d    = f3_q;
    load_d  = load_q;
    err_d   = 1'b0;
    mis_d   = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (access && bad_align) begin
          state_d = DONE;
          mis_d   = 1'b1;
          load_d  = 32'b0;
        end else if (access) begin
          state_d = REQ;
          req_d   = 1'b1;
          we_d    = mem_write;
          addr_d  = {addr[31:2], 2'b00};
          off_d   = addr[1:0];
          f3_d    = funct3;
          cnt_d   = '0;
          case (funct3)
            3'b000: begin
              wdata_d = {4{store_data[7:0]}};
              be_d    = 4'b0001 << addr[1:0];
            end
            3'b001: begin
              wdata_d = {2{store_data[15:0]}};
              be_d    = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
              wdata_d = store_data;
              be_d    = 4'b1111;
            end
          endcase
        end
      end
      REQ: begin
        if (mem_ack) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (!we_q) load_d = fmt_load(f3_q, off_q, mem_rdata);
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          req_d   = 1'b0;
          load_d  = 32'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'b0;
      wdata_q <= 32'b0;
      be_q    <= 4'b0;
      off_q   <= 2'b0;
      f3_q    <= 3'b0;
      load_q  <= 32'b0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      load_q  <= load_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    busywait = 1'b0;
    case (state_q)
      IDLE:    busywait = access;
      REQ:     busywait = 1'b1;
      default: busywait = 1'b0;
    endcase
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign load_data = load_q;
  assign bus_err   = err_q;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = mis_q;
`else
  assign misaligned = 1'b0;
`endif

endmodule
